// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the unified memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } data_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_DM = 3'd2,
        RESP_IF = 3'd3,
        RESP_DM = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } arb_owner_e;

    localparam int c_STREAK_W = 4;

    function automatic arb_owner_e state_owner(arb_state_e s);
        return ((s == BUSY_DM) || (s == RESP_DM)) ? OWNER_DM : OWNER_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_watchdog
// Description : BUSY-state watchdog; expires on the TIMEOUT_CYCLES-th counted
//               cycle. Only built when MEM_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_count,
    input  logic i_clear,
    output logic o_expire
);
    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_count && (r_cnt_q != c_LAST)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_expire = i_count && (r_cnt_q == c_LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and data stage; data wins
//               unless its grant streak reaches MAX_DATA_STREAK. Optional
//               watchdog and err_o enabled by MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  data_size_e  dm_size_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output data_size_e  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        err_o
`endif
);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_STREAK);

    // Marker block: elaborates only for out-of-range parameter values.
    if ((MAX_DATA_STREAK < 1) || (MAX_DATA_STREAK > 15) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    end

    arb_state_e            r_state_q,     w_state_d;
    logic [c_STREAK_W-1:0] r_streak_q,    w_streak_d;
    logic                  r_mem_req_q,   w_mem_req_d;
    logic                  r_mem_we_q,    w_mem_we_d;
    data_size_e            r_mem_size_q,  w_mem_size_d;
    logic [31:0]           r_mem_addr_q,  w_mem_addr_d;
    logic [31:0]           r_mem_wdata_q, w_mem_wdata_d;
    logic                  r_if_ready_q,  w_if_ready_d;
    logic                  r_dm_ready_q,  w_dm_ready_d;
    logic [31:0]           r_if_rdata_q,  w_if_rdata_d;
    logic [31:0]           r_dm_rdata_q,  w_dm_rdata_d;

    logic        w_busy;
    logic        w_grant_dm;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    assign w_busy     = (r_state_q == BUSY_IF) || (r_state_q == BUSY_DM);
    assign w_grant_dm = dm_req_i && !(if_req_i && (r_streak_q == c_STREAK_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    logic r_err_q, w_err_d;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_count  (w_busy),
        .i_clear  (!w_busy),
        .o_expire (w_timeout)
    );

    assign err_o = r_err_q;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_streak_d    = r_streak_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_size_d  = r_mem_size_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_if_ready_d  = 1'b0;
        w_dm_ready_d  = 1'b0;
        w_if_rdata_d  = r_if_rdata_q;
        w_dm_rdata_d  = r_dm_rdata_q;
        w_done        = 1'b0;
        w_rdata       = 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_err_d       = r_err_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (w_grant_dm) begin
                    w_state_d     = BUSY_DM;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = dm_we_i;
                    w_mem_size_d  = dm_size_i;
                    w_mem_addr_d  = dm_addr_i;
                    w_mem_wdata_d = dm_wdata_i;
                    // Streak only grows while fetch is actually being held off.
                    if (!if_req_i) begin
                        w_streak_d = '0;
                    end else if (r_streak_q != c_STREAK_MAX) begin
                        w_streak_d = r_streak_q + 1'b1;
                    end
                end else if (if_req_i) begin
                    w_state_d     = BUSY_IF;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = 1'b0;
                    w_mem_size_d  = SIZE_WORD;
                    w_mem_addr_d  = if_addr_i;
                    w_mem_wdata_d = 32'h0;
                    w_streak_d    = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready_i) begin
                    w_done  = 1'b1;
                    w_rdata = mem_rdata_i;
                end else if (w_timeout) begin
                    w_done  = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_err_d = 1'b1;
`endif
                end
                if (w_done) begin
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    if (state_owner(r_state_q) == OWNER_IF) begin
                        w_state_d    = RESP_IF;
                        w_if_ready_d = 1'b1;
                        w_if_rdata_d = w_rdata;
                    end else begin
                        w_state_d    = RESP_DM;
                        w_dm_ready_d = 1'b1;
                        w_dm_rdata_d = w_rdata;
                    end
                end
            end
            RESP_IF, RESP_DM: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_streak_q    <= '0;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_size_q  <= SIZE_BYTE;
            r_mem_addr_q  <= 32'h0;
            r_mem_wdata_q <= 32'h0;
            r_if_ready_q  <= 1'b0;
            r_dm_ready_q  <= 1'b0;
            r_if_rdata_q  <= 32'h0;
            r_dm_rdata_q  <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_err_q       <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_streak_q    <= w_streak_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_size_q  <= w_mem_size_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_if_ready_q  <= w_if_ready_d;
            r_dm_ready_q  <= w_dm_ready_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_dm_rdata_q  <= w_dm_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            r_err_q       <= w_err_d;
`endif
        end
    end

    assign if_ready_o  = r_if_ready_q;
    assign if_rdata_o  = r_if_rdata_q;
    assign dm_ready_o  = r_dm_ready_q;
    assign dm_rdata_o  = r_dm_rdata_q;
    assign mem_req_o   = r_mem_req_q;
    assign mem_we_o    = r_mem_we_q;
    assign mem_size_o  = r_mem_size_q;
    assign mem_addr_o  = r_mem_addr_q;
    assign mem_wdata_o = r_mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter; covers the watchdog
//               when MEM_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int c_MAX = 4;
    localparam int c_TO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    data_size_e  dm_size_i;
    logic        if_ready_o, dm_ready_o, mem_req_o, mem_we_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    data_size_e  mem_size_o;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        err_o;
`endif

    mem_port_arbiter #(
        .MAX_DATA_STREAK (c_MAX),
        .TIMEOUT_CYCLES  (c_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_ready_o  (if_ready_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_size_i   (dm_size_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_ready_o  (dm_ready_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_size_o  (mem_size_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        int          len;
        logic [31:0] addr;
        logic        we;
        data_size_e  size;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t if_q[$];
    rsp_exp_t dm_q[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    int err_cyc = 1 << 30;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares whatever the DUT presents against the queued expectations.
    mem_exp_t mon_me;
    rsp_exp_t mon_re;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_q.size() > 0 && cyc >= mem_q[0].start) begin
                mon_me = mem_q[0];
                checks++;
                if (!(mem_req_o && mem_addr_o == mon_me.addr && mem_we_o == mon_me.we &&
                      mem_size_o == mon_me.size && mem_wdata_o == mon_me.wdata)) begin
                    errors++;
                    $display("FAIL mem_busy cyc=%0d: got req=%b addr=%h we=%b size=%0d wdata=%h, required req=1 addr=%h we=%b size=%0d wdata=%h",
                             cyc, mem_req_o, mem_addr_o, mem_we_o, mem_size_o, mem_wdata_o,
                             mon_me.addr, mon_me.we, mon_me.size, mon_me.wdata);
                end
                if (cyc >= mon_me.start + mon_me.len - 1) void'(mem_q.pop_front());
            end else begin
                checks++;
                if (mem_req_o || mem_we_o) begin
                    errors++;
                    $display("FAIL mem_idle cyc=%0d: got req=%b we=%b, required req=0 we=0",
                             cyc, mem_req_o, mem_we_o);
                end
            end

            if (if_ready_o || (if_q.size() > 0 && cyc >= if_q[0].cyc)) begin
                checks++;
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_ready cyc=%0d: got unexpected pulse rdata=%h, required no pulse", cyc, if_rdata_o);
                end else begin
                    mon_re = if_q.pop_front();
                    if (!(if_ready_o && cyc == mon_re.cyc && if_rdata_o == mon_re.rdata)) begin
                        errors++;
                        $display("FAIL if_ready cyc=%0d: got ready=%b rdata=%h, required ready=1 at cyc=%0d rdata=%h",
                                 cyc, if_ready_o, if_rdata_o, mon_re.cyc, mon_re.rdata);
                    end
                end
            end

            if (dm_ready_o || (dm_q.size() > 0 && cyc >= dm_q[0].cyc)) begin
                checks++;
                if (dm_q.size() == 0) begin
                    errors++;
                    $display("FAIL dm_ready cyc=%0d: got unexpected pulse rdata=%h, required no pulse", cyc, dm_rdata_o);
                end else begin
                    mon_re = dm_q.pop_front();
                    if (!(dm_ready_o && cyc == mon_re.cyc && dm_rdata_o == mon_re.rdata)) begin
                        errors++;
                        $display("FAIL dm_ready cyc=%0d: got ready=%b rdata=%h, required ready=1 at cyc=%0d rdata=%h",
                                 cyc, dm_ready_o, dm_rdata_o, mon_re.cyc, mon_re.rdata);
                    end
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            checks++;
            if (err_o !== (cyc >= err_cyc)) begin
                errors++;
                $display("FAIL err_flag cyc=%0d: got %b, required %b", cyc, err_o, (cyc >= err_cyc));
            end
`endif
        end
    end

    // Requester and memory state kept by the reference model.
    bit          if_pend = 1'b0, dm_pend = 1'b0;
    logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0, rd_val = '0, force_rd = '0;
    logic        dm_w = 1'b0;
    data_size_e  dm_sz = SIZE_WORD;
    int          if_done = -10, dm_done = -10, next_idle = 0, streak = 0;
    int          busy_lo = -10, busy_hi = -10, rdy_cyc = -10;
    int          gen_mode = 0, force_lat = 0;
    bit          force_rd_en = 1'b0, spur_en = 1'b0;

    task automatic new_if();
        if_pend = 1'b1;
        if_a    = $urandom;
    endtask

    task automatic new_dm();
        dm_pend = 1'b1;
        dm_a    = $urandom;
        dm_wd   = $urandom;
        dm_w    = 1'($urandom_range(0, 1));
        dm_sz   = data_size_e'($urandom_range(0, 2));
    endtask

    task automatic step();
        int       t = cyc;
        bit       gdm;
        int       lat;
        logic [31:0] rd;
        mem_exp_t me;
        rsp_exp_t re;
        if (t == if_done + 1) begin if_pend = 1'b0; if_done = -10; end
        if (t == dm_done + 1) begin dm_pend = 1'b0; dm_done = -10; end
        if (gen_mode == 1) begin
            if (!if_pend && $urandom_range(0, 2) == 0) new_if();
            if (!dm_pend && $urandom_range(0, 1) == 0) new_dm();
        end else if (gen_mode == 2) begin
            if (!if_pend) new_if();
            if (!dm_pend) new_dm();
        end
        if (t == next_idle) begin
            if (if_pend || dm_pend) begin
                // Data first, unless fetch has already waited out c_MAX data grants.
                gdm    = dm_pend && !(if_pend && streak == c_MAX);
                streak = (gdm && if_pend) ? ((streak < c_MAX) ? streak + 1 : c_MAX) : 0;
                lat    = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
                rd     = force_rd_en ? force_rd : $urandom;
                me.start = t + 1;
                me.addr  = gdm ? dm_a : if_a;
                me.we    = gdm ? dm_w : 1'b0;
                me.size  = gdm ? dm_sz : SIZE_WORD;
                me.wdata = gdm ? dm_wd : 32'h0;
                busy_lo  = t + 1;
`ifdef MEM_ARB_TIMEOUT_EN
                if (lat > c_TO) begin
                    me.len   = c_TO;
                    rdy_cyc  = -10;
                    busy_hi  = t + c_TO;
                    re.cyc   = t + c_TO + 1;
                    re.rdata = 32'h0;
                    if (err_cyc > re.cyc) err_cyc = re.cyc;
                end else
`endif
                begin
                    me.len   = lat;
                    rdy_cyc  = t + lat;
                    busy_hi  = t + lat;
                    re.cyc   = t + lat + 1;
                    re.rdata = rd;
                    rd_val   = rd;
                end
                mem_q.push_back(me);
                if (gdm) begin dm_q.push_back(re); dm_done = re.cyc; end
                else     begin if_q.push_back(re); if_done = re.cyc; end
                next_idle = re.cyc + 1;
            end else begin
                next_idle = t + 1;
            end
        end
        if_req_i   = if_pend;
        if_addr_i  = if_a;
        dm_req_i   = dm_pend;
        dm_addr_i  = dm_a;
        dm_wdata_i = dm_wd;
        dm_we_i    = dm_w;
        dm_size_i  = dm_sz;
        if (t == rdy_cyc) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = rd_val;
        end else if (t >= busy_lo && t <= busy_hi) begin
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
        end else begin
            mem_ready_i = spur_en && ($urandom_range(0, 3) == 0);
            mem_rdata_i = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        mon_en      = 1'b0;
        rst         = 1'b1;
        if_req_i    = 1'b0;
        dm_req_i    = 1'b0;
        mem_ready_i = 1'b0;
        if_pend     = 1'b0;
        dm_pend     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_q.delete();
        if_q.delete();
        dm_q.delete();
        streak    = 0;
        next_idle = cyc;
        if_done   = -10;
        dm_done   = -10;
        rdy_cyc   = -10;
        busy_lo   = -10;
        busy_hi   = -10;
        err_cyc   = 1 << 30;
        mon_en    = 1'b1;
    endtask

    initial begin
        rst = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; dm_size_i = SIZE_BYTE;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();

        // Lone fetch, memory answers on the second BUSY cycle.
        if_pend = 1'b1; if_a = 32'h100;
        force_lat = 2; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
        run(6);

        // Lone byte store held through a 5-cycle memory latency.
        dm_pend = 1'b1; dm_a = 32'h2000; dm_wd = 32'h1234_5678; dm_w = 1'b1; dm_sz = SIZE_BYTE;
        force_lat = 5; force_rd = 32'hCAFE_0001;
        run(10);
        force_rd_en = 1'b0;

        // Both requesters saturate the port: streak forces fetch through every 5th grant.
        gen_mode = 2; force_lat = 1; run(40);
        force_lat = 0; run(40);
        gen_mode = 0; run(20);

        // Stray mem_ready_i in IDLE and RESP must be ignored.
        spur_en = 1'b1; new_if(); force_lat = 1; run(10);
        new_dm(); run(10);
        spur_en = 1'b0;

        // Reset lands during BUSY_DM, then a fresh fetch completes normally.
        new_dm(); dm_w = 1'b0; force_lat = 5; run(2);
        apply_reset();
        force_lat = 0; new_if(); run(10);

        gen_mode = 1; spur_en = 1'b1; run(3000);
        gen_mode = 0; spur_en = 1'b0; run(20);

`ifdef MEM_ARB_TIMEOUT_EN
        // mem_ready_i on the expiring cycle wins; then a real timeout sets err_o.
        new_dm(); force_lat = c_TO; run(c_TO + 4);
        new_dm(); force_lat = 100; run(c_TO + 4);
        new_if(); force_lat = 2; run(10);
        force_lat = 0;
        apply_reset();
        run(5);
`endif

        checks++;
        if (mem_q.size() != 0 || if_q.size() != 0 || dm_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d pending mem/if/dm expectations, required 0/0/0",
                     mem_q.size(), if_q.size(), dm_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
